mdio_controller: RTL and testbench

MDIO_CONTROLLER -- requirements
Module: mdio_controller

---
 rtl/mdio_pkg.sv | 45 ++++
 rtl/mdio_clkgen.sv | 23 ++
 rtl/mdio_controller.sv | 111 +++++++++++
 tb/tb_mdio_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared constants for the MDIO management controller: frame layout,
// ST/OP codes, datapath widths and FSM state encoding.
package mdio_pkg;

  localparam int FRAME_W = 32;
  localparam int DATA_W  = 16;
  localparam int CNT_W   = 5;

  // Frame field bit positions within the 32-bit frame word
  localparam int ST_MSB    = 31;
  localparam int ST_LSB    = 30;
  localparam int OP_MSB    = 29;
  localparam int OP_LSB    = 28;
  localparam int PHYAD_MSB = 27;
  localparam int PHYAD_LSB = 23;
  localparam int REGAD_MSB = 22;
  localparam int REGAD_LSB = 18;
  localparam int TA_MSB    = 17;
  localparam int TA_LSB    = 16;
  localparam int DATA_MSB  = 15;
  localparam int DATA_LSB  = 0;

  localparam logic [1:0] ST    = 2'b01;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;

  // Last header bit the controller drives in a read frame
  localparam logic [CNT_W-1:0] HDR_LAST_BIT = CNT_W'(TA_LSB);
  localparam logic [CNT_W-1:0] FIRST_BIT    = CNT_W'(FRAME_W - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_FRAME = 3'd1;
  localparam logic [2:0] S_RD_HDR   = 3'd2;
  localparam logic [2:0] S_RD_DATA  = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  function automatic logic is_write(input logic [3:0] st_op);
    return st_op == {ST, OP_WR};
  endfunction

  function automatic logic is_read(input logic [3:0] st_op);
    return st_op == {ST, OP_RD};
  endfunction

endpackage

// File: rtl/mdio_clkgen.sv
// MDC generator: divides the system clock by two and flags which edge of
// the system clock is the drive point (MDC falls) or sample point (MDC rises).
module mdio_clkgen (
  input  logic clk,
  input  logic rst_n,
  output logic mdc,
  output logic drive_pt,
  output logic sample_pt
);

  logic mdc_q;

  // MDC toggles every system clock; first edge after reset brings it high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdc_q <= 1'b0;
    else        mdc_q <= ~mdc_q;
  end

  assign mdc       = mdc_q;
  assign drive_pt  = mdc_q;
  assign sample_pt = ~mdc_q;

endmodule

// File: rtl/mdio_controller.sv
// MDIO management frame controller: shifts out a 32-bit write frame, or a
// 16-bit read header followed by capture of 16 data bits from the PHY.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for MDIO_START; frame word latched on the request
// WR_FRAME | driving all 32 frame bits, MSB first
// RD_HDR   | driving header bits 31..16
// RD_DATA  | bus released, shifting MDIO_IN in at each sample point
// DONE     | one-cycle completion pulse, then back to IDLE
module mdio_controller
  import mdio_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MDIO_START,
  input  logic [FRAME_W-1:0] T_DATA,
  input  logic              MDIO_IN,
  output logic              MDC,
  output logic              MDIO_OUT,
  output logic              MDIO_OE,
  output logic              MDIO_DONE,
  output logic [DATA_W-1:0] RD_DATA
);

  logic               drive_pt;
  logic               sample_pt;
  logic [2:0]         state_q;
  logic [FRAME_W-1:0] frame_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  // The latch edge need not be a drive point, so the first bit only goes on
  // the line at the next drive point; this flag marks that it has.
  logic               bit_on_q;
  logic [DATA_W-1:0]  shift_q;
  logic [DATA_W-1:0]  rd_data_q;

  mdio_clkgen u_clkgen (
    .clk      (CLK),
    .rst_n    (RESET),
    .mdc      (MDC),
    .drive_pt (drive_pt),
    .sample_pt(sample_pt)
  );

  // Frame sequencing: latch, shift out on drive points, capture on sample points
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      bit_on_q  <= 1'b0;
      shift_q   <= '0;
      rd_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (MDIO_START) begin
            frame_q   <= T_DATA;
            bit_cnt_q <= FIRST_BIT;
            bit_on_q  <= 1'b0;
            if (is_write(T_DATA[ST_MSB:OP_LSB]))     state_q <= S_WR_FRAME;
            else if (is_read(T_DATA[ST_MSB:OP_LSB])) state_q <= S_RD_HDR;
          end
        end
        S_WR_FRAME: begin
          if (drive_pt) begin
            if (!bit_on_q) begin
              bit_on_q <= 1'b1;
            end else if (bit_cnt_q == '0) begin
              bit_on_q <= 1'b0;
              state_q  <= S_DONE;
            end else begin
              bit_cnt_q <= bit_cnt_q - 5'd1;
            end
          end
        end
        S_RD_HDR: begin
          if (drive_pt) begin
            if (!bit_on_q) begin
              bit_on_q <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q - 5'd1;
              if (bit_cnt_q == HDR_LAST_BIT) state_q <= S_RD_DATA;
            end
          end
        end
        S_RD_DATA: begin
          if (sample_pt) shift_q <= {shift_q[DATA_W-2:0], MDIO_IN};
          if (drive_pt) begin
            if (bit_cnt_q == '0) begin
              bit_on_q  <= 1'b0;
              rd_data_q <= shift_q;
              state_q   <= S_DONE;
            end else begin
              bit_cnt_q <= bit_cnt_q - 5'd1;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state so an async reset clears them immediately
  assign MDIO_OE   = bit_on_q && ((state_q == S_WR_FRAME) || (state_q == S_RD_HDR));
  assign MDIO_OUT  = MDIO_OE & frame_q[bit_cnt_q];
  assign MDIO_DONE = (state_q == S_DONE);
  assign RD_DATA   = rd_data_q;

endmodule

// File: tb/tb_mdio_controller.sv
// Self-checking bench for mdio_controller: a frame-timeline model predicts
// every output each cycle; directed scenarios add literal expectations.
module tb_mdio_controller;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        MDIO_START = 1'b0;
  logic [31:0] T_DATA = 32'h0;
  logic        MDIO_IN = 1'b0;
  logic        MDC, MDIO_OUT, MDIO_OE, MDIO_DONE;
  logic [15:0] RD_DATA;

  mdio_controller dut (
    .CLK(CLK), .RESET(RESET), .MDIO_START(MDIO_START), .T_DATA(T_DATA),
    .MDIO_IN(MDIO_IN), .MDC(MDC), .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE),
    .MDIO_DONE(MDIO_DONE), .RD_DATA(RD_DATA)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 latched/waiting for first drive point,
  // 2 frame running (m_t = CLK cycles since first drive point), 3 done pulse.
  int          n_edge = 0;
  int          m_phase = 0;
  int          m_t = 0;
  logic        m_rd = 1'b0;
  logic [31:0] m_frame = 32'h0;
  logic [15:0] m_phy = 16'h0;
  logic [15:0] m_rd_data = 16'h0;
  logic [15:0] phy_word = 16'h0;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      n_edge = 0; m_phase = 0; m_t = 0; m_rd_data = 16'h0;
    end else begin
      n_edge++;
      case (m_phase)
        0: if (MDIO_START) begin
             m_frame = T_DATA;
             m_phy   = phy_word;
             if (T_DATA[31:28] == 4'h5)      begin m_phase = 1; m_rd = 1'b0; end
             else if (T_DATA[31:28] == 4'h6) begin m_phase = 1; m_rd = 1'b1; end
           end
        1: if (n_edge % 2 == 0) begin m_phase = 2; m_t = 0; end
        2: begin
             m_t++;
             if (m_t == 64) begin
               m_phase = 3;
               if (m_rd) m_rd_data = m_phy;
             end
           end
        default: m_phase = 0;
      endcase
    end
  end

  // PHY: answers with its word during the data half, noise elsewhere
  always @(negedge CLK) begin
    if (m_phase == 2 && m_rd && m_t >= 32) MDIO_IN = m_phy[15 - (m_t - 32) / 2];
    else                                   MDIO_IN = 1'($urandom_range(0, 1));
  end

  // Observation counters for directed scenarios (never cleared; use deltas)
  logic [31:0] seen = 32'h0;
  int          seen_cnt = 0;
  int          done_cnt = 0;
  int          oe_cycles = 0;
  logic [15:0] rd_at_done = 16'h0;

  // Per-cycle compare against the model
  always @(negedge CLK) begin
    logic exp_oe, exp_out, exp_mdc;
    exp_mdc = RESET ? 1'(n_edge % 2) : 1'b0;
    exp_oe  = (m_phase == 2) && (!m_rd || m_t < 32);
    exp_out = exp_oe ? m_frame[31 - m_t / 2] : 1'b0;
    check("mdc", {31'h0, MDC}, {31'h0, exp_mdc});
    check("mdio_oe", {31'h0, MDIO_OE}, {31'h0, exp_oe});
    check("mdio_out", {31'h0, MDIO_OUT}, {31'h0, exp_out});
    check("mdio_done", {31'h0, MDIO_DONE}, {31'h0, 1'(m_phase == 3)});
    check("rd_data", {16'h0, RD_DATA}, {16'h0, m_rd_data});
    if (MDIO_OE) oe_cycles++;
    if (MDIO_OE && m_phase == 2 && m_t % 2 == 0) begin
      seen = {seen[30:0], MDIO_OUT};
      seen_cnt++;
    end
    if (MDIO_DONE) begin
      done_cnt++;
      rd_at_done = RD_DATA;
    end
  end

  task automatic step(input int k = 1);
    repeat (k) begin @(negedge CLK); #1; end
  endtask

  task automatic pulse(input logic [31:0] d);
    T_DATA = d; MDIO_START = 1'b1; step(); MDIO_START = 1'b0;
  endtask

  task automatic reset_literals(input string tag);
    check({tag, "_mdc"}, {31'h0, MDC}, 32'h0);
    check({tag, "_oe"}, {31'h0, MDIO_OE}, 32'h0);
    check({tag, "_out"}, {31'h0, MDIO_OUT}, 32'h0);
    check({tag, "_done"}, {31'h0, MDIO_DONE}, 32'h0);
    check({tag, "_rd"}, {16'h0, RD_DATA}, 32'h0);
  endtask

  initial begin
    int d0, s0, o0, k;
    logic [31:0] w;

    // Reset holds everything at zero; MDC rises on the first edge after release
    step(3);
    reset_literals("reset");
    RESET = 1'b1;
    @(negedge CLK);
    check("mdc_first_rise", {31'h0, MDC}, 32'h1);
    #1;

    // Write frame
    d0 = done_cnt; s0 = seen_cnt; o0 = oe_cycles;
    pulse(32'h5A3C_BEEF); step(72);
    check("wr_bits", seen, 32'h5A3C_BEEF);
    check("wr_bitcnt", seen_cnt - s0, 32);
    check("wr_oe_cycles", oe_cycles - o0, 64);
    check("wr_done_once", done_cnt - d0, 1);
    check("wr_rd_unchanged", {16'h0, RD_DATA}, 32'h0);

    // Read frame
    d0 = done_cnt; s0 = seen_cnt; o0 = oe_cycles;
    phy_word = 16'h8FF1; pulse(32'h6AB4_0000); step(72);
    check("rd_hdr_bits", {16'h0, seen[15:0]}, 32'h6AB4);
    check("rd_oe_cycles", oe_cycles - o0, 32);
    check("rd_done_once", done_cnt - d0, 1);
    check("rd_data_at_done", {16'h0, rd_at_done}, 32'h8FF1);

    // Busy: second request during a read is ignored
    d0 = done_cnt; s0 = seen_cnt;
    phy_word = 16'h1357; pulse(32'h6123_0000); step(10);
    phy_word = 16'hFFFF; pulse(32'h5000_1234); step(62);
    check("busy_done_once", done_cnt - d0, 1);
    check("busy_hdr_only", seen_cnt - s0, 16);
    check("busy_hdr_bits", {16'h0, seen[15:0]}, 32'h6123);
    check("busy_rd_data", {16'h0, RD_DATA}, 32'h1357);

    // Invalid opcode: no activity
    d0 = done_cnt; o0 = oe_cycles;
    pulse(32'h7000_0000); step(70);
    check("inv_no_oe", oe_cycles - o0, 0);
    check("inv_no_done", done_cnt - d0, 0);

    // Reset at bit 10 of a read, then a normal write
    d0 = done_cnt;
    phy_word = 16'h2222; pulse(32'h6AB4_0000);
    k = 0;
    while (!(m_phase == 2 && m_t == 20) && k < 60) begin step(); k++; end
    check("reach_bit10", {31'h0, 1'(k < 60)}, 32'h1);
    RESET = 1'b0; #1;
    reset_literals("midreset");
    step(2); RESET = 1'b1; step();
    pulse(32'h5155_AA55); step(72);
    check("postreset_bits", seen, 32'h5155_AA55);
    check("postreset_done_once", done_cnt - d0, 1);

    // Back-to-back with MDIO_START held high
    d0 = done_cnt; s0 = seen_cnt;
    T_DATA = 32'h5ACE_0F0F; MDIO_START = 1'b1;
    k = 0;
    while (done_cnt - d0 < 2 && k < 200) begin step(); k++; end
    MDIO_START = 1'b0;
    check("b2b_two_frames", done_cnt - d0, 2);
    step(70);
    check("b2b_no_third", done_cnt - d0, 2);
    check("b2b_bits", seen_cnt - s0, 64);

    // Randomized frames, stray requests and occasional mid-frame resets
    for (int i = 0; i < 30; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      w = $urandom;
      if (kind < 4)      w[31:28] = 4'h5;
      else if (kind < 8) w[31:28] = 4'h6;
      else if (w[31:28] == 4'h5 || w[31:28] == 4'h6) w[31:28] = 4'h7;
      phy_word = 16'($urandom);
      step($urandom_range(0, 3));
      pulse(w);
      if (kind == 9) begin
        w[31:28] = 4'h6; pulse(w);
        step($urandom_range(5, 60));
        RESET = 1'b0; step($urandom_range(1, 2)); RESET = 1'b1;
      end
      for (int j = 0; j < 3; j++) begin
        step($urandom_range(5, 20));
        if ($urandom_range(0, 1) == 1) pulse($urandom);
      end
      step(72);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
